// File: rtl/arith_scheduler.sv
// Round-robin scheduler sharing one 8-bit arithmetic unit among NREQ requesters.
// One operation is in flight at a time; results return on a valid/ready bus.
module arith_scheduler #(
  parameter int NREQ     = 4,
  parameter int EXEC_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [1:0]        alu_sel,
  output logic              alu_el,
  input  logic [15:0]       alu_y,
  output logic [15:0]       res_y,
  output logic [2:0]        res_id,
  output logic              res_err,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  localparam int CW = $clog2(EXEC_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [NREQ-1:0] ack_r, ack_s;
  logic [7:0]      a_r, a_s, b_r, b_s;
  logic [1:0]      sel_r, sel_s;
  logic            el_r, el_s;
  logic [15:0]     y_r, y_s;
  logic [2:0]      id_r, id_s;
  logic            err_r, err_s;
  logic            valid_r, valid_s;
  logic            busy_r, busy_s;
  logic [2:0]      last_r, last_s;
  logic [2:0]      own_r, own_s;
  logic [CW-1:0]   cnt_r, cnt_s;

  logic [2:0]      win_s;
  logic            found_s;
  int              idx_s;
  logic [7:0]      pick_a_s, pick_b_s;
  logic [1:0]      pick_op_s;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    win_s   = 3'd0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_s = (int'(last_r) + i) % NREQ;
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = 3'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign pick_a_s  = req_a[{win_s, 3'b000} +: 8];
  assign pick_b_s  = req_b[{win_s, 3'b000} +: 8];
  assign pick_op_s = req_op[{win_s, 1'b0} +: 2];

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_s = state_r;
    ack_s   = '0;
    a_s     = a_r;
    b_s     = b_r;
    sel_s   = sel_r;
    el_s    = el_r;
    y_s     = y_r;
    id_s    = id_r;
    err_s   = err_r;
    valid_s = valid_r;
    last_s  = last_r;
    own_s   = own_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          a_s          = pick_a_s;
          b_s          = pick_b_s;
          sel_s        = pick_op_s;
          own_s        = win_s;
          ack_s[win_s] = 1'b1;
          // Divide by zero never reaches the unit: answer immediately.
          if (pick_op_s == 2'b11 && pick_b_s == 8'd0) begin
            y_s     = 16'hFFFF;
            err_s   = 1'b1;
            id_s    = win_s;
            valid_s = 1'b1;
            state_s = RESP;
          end else begin
            cnt_s   = '0;
            el_s    = 1'b0;
            state_s = EXEC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == CW'(EXEC_CYC - 1)) begin
          y_s     = alu_y;
          err_s   = 1'b0;
          id_s    = own_r;
          valid_s = 1'b1;
          el_s    = 1'b1;
          state_s = RESP;
        end else begin
          cnt_s   = cnt_r + CW'(1);
          state_s = EXEC;
        end
      end
      RESP: begin
        if (res_ready) begin
          valid_s = 1'b0;
          last_s  = own_r;
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        el_s    = 1'b1;
        valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ack_r   <= '0;
      a_r     <= 8'd0;
      b_r     <= 8'd0;
      sel_r   <= 2'd0;
      el_r    <= 1'b1;
      y_r     <= 16'd0;
      id_r    <= 3'd0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      last_r  <= 3'(NREQ - 1);
      own_r   <= 3'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      ack_r   <= ack_s;
      a_r     <= a_s;
      b_r     <= b_s;
      sel_r   <= sel_s;
      el_r    <= el_s;
      y_r     <= y_s;
      id_r    <= id_s;
      err_r   <= err_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      last_r  <= last_s;
      own_r   <= own_s;
      cnt_r   <= cnt_s;
    end
  end

  assign req_ack   = ack_r;
  assign alu_a     = a_r;
  assign alu_b     = b_r;
  assign alu_sel   = sel_r;
  assign alu_el    = el_r;
  assign res_y     = y_r;
  assign res_id    = id_r;
  assign res_err   = err_r;
  assign res_valid = valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_arith_scheduler.sv
// Bench for arith_scheduler: directed table, round-robin and reset sequences,
// then randomized transactions checked against a transaction-level reference model.
module tb_arith_scheduler;
  localparam int NREQ     = 4;
  localparam int EXEC_CYC = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] req_a = '0;
  logic [NREQ*8-1:0] req_b = '0;
  logic [NREQ*2-1:0] req_op = '0;
  logic [NREQ-1:0]   req_ack;
  logic [7:0]        alu_a, alu_b;
  logic [1:0]        alu_sel;
  logic              alu_el;
  logic [15:0]       alu_y;
  logic [15:0]       res_y;
  logic [2:0]        res_id;
  logic              res_err, res_valid, busy;
  logic              res_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  int m_last = NREQ - 1;

  always #5 clk = ~clk;

  arith_scheduler #(.NREQ(NREQ), .EXEC_CYC(EXEC_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ack(req_ack), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_el(alu_el),
    .alu_y(alu_y), .res_y(res_y), .res_id(res_id), .res_err(res_err),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return 16'(a) + 16'(b);
      2'b01:   return 16'(a) - 16'(b);
      2'b10:   return 16'(a) * 16'(b);
      default: return (b == 8'd0) ? 16'hFFFF : 16'(a / b);
    endcase
  endfunction

  // Arithmetic unit stand-in: output is garbage-free only while enabled.
  assign alu_y = alu_el ? 16'h0000 : ref_alu(alu_a, alu_b, alu_sel);

  function automatic int ref_winner(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, 32'(req_ack), 32'd0);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_sel"}, 32'(alu_sel), 32'd0);
    check({tag, "_el"}, 32'(alu_el), 32'd1);
    check({tag, "_res_y"}, 32'(res_y), 32'd0);
    check({tag, "_res_id"}, 32'(res_id), 32'd0);
    check({tag, "_err"}, 32'(res_err), 32'd0);
    check({tag, "_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One full transaction from the current (held) request inputs through the handshake.
  task automatic run_txn(input int hold, output int got_w, output logic [15:0] got_y,
                         output logic got_err);
    int exp_w;
    int cyc;
    logic [7:0] ea, eb;
    logic [1:0] eo;
    logic [15:0] ey;
    logic ee;
    res_ready = 1'b0;
    exp_w = ref_winner(req, m_last);
    ea = req_a[8*exp_w +: 8];
    eb = req_b[8*exp_w +: 8];
    eo = req_op[2*exp_w +: 2];
    ee = (eo == 2'b11) && (eb == 8'd0);
    ey = ee ? 16'hFFFF : ref_alu(ea, eb, eo);
    got_w = -1;
    got_y = 16'd0;
    got_err = 1'b0;
    cyc = 0;
    while (req_ack == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ack_seen", 32'(req_ack != '0), 32'd1);
    if (req_ack == '0) return;
    for (int i = 0; i < NREQ; i++) if (req_ack[i]) got_w = i;
    check("ack_onehot", 32'(req_ack), 32'(1) << exp_w);
    check("busy_on_ack", 32'(busy), 32'd1);
    if (!ee) begin
      for (int k = 0; k < EXEC_CYC; k++) begin
        check("el_low", 32'(alu_el), 32'd0);
        check("valid_early", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("ack_pulse", 32'(req_ack), 32'd0);
      end
    end else begin
      check("el_div0", 32'(alu_el), 32'd1);
    end
    check("valid", 32'(res_valid), 32'd1);
    check("el_resp", 32'(alu_el), 32'd1);
    check("res_y", 32'(res_y), 32'(ey));
    check("res_id", 32'(res_id), 32'(exp_w));
    check("res_err", 32'(res_err), 32'(ee));
    got_y = res_y;
    got_err = res_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_y", 32'(res_y), 32'(ey));
      check("hold_id", 32'(res_id), 32'(exp_w));
      check("hold_no_ack", 32'(req_ack), 32'd0);
      check("hold_el", 32'(alu_el), 32'd1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_drop", 32'(res_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("bubble_no_ack", 32'(req_ack), 32'd0);
    m_last = exp_w;
  endtask

  typedef struct {
    int          who;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic [15:0] y;
    logic        err;
  } vec_t;

  vec_t vecs[6];
  int   exp_rr[6];
  logic [NREQ-1:0] rr_req[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [15:0] y;
    logic e;
    int cyc;

    vecs[0] = '{0, 8'd200, 8'd100, 2'b00, 16'd300,   1'b0};
    vecs[1] = '{1, 8'd255, 8'd255, 2'b10, 16'hFE01,  1'b0};
    vecs[2] = '{2, 8'd200, 8'd7,   2'b11, 16'd28,    1'b0};
    vecs[3] = '{3, 8'd5,   8'd10,  2'b01, 16'hFFFB,  1'b0};
    vecs[4] = '{0, 8'd9,   8'd0,   2'b11, 16'hFFFF,  1'b1};
    vecs[5] = '{2, 8'd0,   8'd0,   2'b10, 16'd0,     1'b0};
    exp_rr = '{0, 1, 2, 3, 0, 3};
    rr_req = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1001, 4'b1001};

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle_noreq");

    // Directed table: each vector uses a single requester.
    for (int i = 0; i < 6; i++) begin
      req = '0;
      req[vecs[i].who] = 1'b1;
      req_a[8*vecs[i].who +: 8] = vecs[i].a;
      req_b[8*vecs[i].who +: 8] = vecs[i].b;
      req_op[2*vecs[i].who +: 2] = vecs[i].op;
      run_txn(0, w, y, e);
      check("tbl_id", 32'(w), 32'(vecs[i].who));
      check("tbl_y", 32'(y), 32'(vecs[i].y));
      check("tbl_err", 32'(e), 32'(vecs[i].err));
    end

    // Round-robin order starting after requester 3.
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'(10 + i);
      req_b[8*i +: 8] = 8'(3);
      req_op[2*i +: 2] = 2'(i);
    end
    req = 4'b1000;
    run_txn(0, w, y, e);
    check("rr_seed", 32'(w), 32'd3);
    for (int i = 0; i < 6; i++) begin
      req = rr_req[i];
      run_txn(0, w, y, e);
      check("rr_order", 32'(w), 32'(exp_rr[i]));
    end

    // Consumer stall with all requesters pending.
    req = 4'b1111;
    run_txn(5, w, y, e);
    check("stall_id", 32'(w), 32'd0);

    // Reset while an operation is executing.
    req = 4'b0001;
    req_a[7:0] = 8'd200;
    req_b[7:0] = 8'd100;
    req_op[1:0] = 2'b00;
    cyc = 0;
    while (req_ack == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_ack", 32'(req_ack), 32'd1);
    check("rst_mid_el", 32'(alu_el), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    req = 4'b0110;
    @(negedge clk);
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    m_last = NREQ - 1;
    run_txn(0, w, y, e);
    check("rst_restart_id", 32'(w), 32'd1);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 150; t++) begin
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        req_a[8*i +: 8] = 8'($urandom);
        req_b[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        req_op[2*i +: 2] = 2'($urandom);
      end
      run_txn(int'($urandom_range(0, 3)), w, y, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
